// File: rtl/mc_bus_pkg.sv
// Shared MCU parallel-bus definitions: register addresses, ID word, STATUS layout
// and the read-responder FSM states. Also imported by the write decoder.
`timescale 1ns/1ps
package mc_bus_pkg;

  localparam logic [5:0] MC_ADDR_ID     = 6'h00;
  localparam logic [5:0] MC_ADDR_STATUS = 6'h01;
  localparam logic [5:0] MC_ADDR_FIFO   = 6'h02;
  localparam logic [5:0] MC_ADDR_PINS   = 6'h03;
  localparam logic [5:0] MC_ADDR_PWM    = 6'h19;

  localparam logic [15:0] MC_ID_VALUE = 16'hB9A1;

  localparam int STAT_OVERFLOW  = 15;
  localparam int STAT_UNDERFLOW = 14;
  localparam int STAT_EMPTY     = 13;
  localparam int STAT_FULL      = 12;
  localparam int STAT_LEVEL_W   = 6;

  typedef enum logic [1:0] {
    RD_ARM,
    RD_IDLE,
    RD_DRIVE
  } rd_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and a separate level counter.
// Push while full is accepted only when a pop happens on the same edge.
`timescale 1ns/1ps
module sync_fifo #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 16,
  parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   rdata,
  output logic               full,
  output logic               empty,
  output logic [LEVEL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               push_ok, pop_ok;

  assign full    = (level_q == LEVEL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // NOTE: every always_comb output gets its default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LEVEL_W'(1);
      2'b01:   level_d = level_q - LEVEL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is not reset; the level counter alone defines which entries are valid.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mc_read_responder.sv
// MCU parallel-bus read path: synchronises the async strobes, decodes the address and
// holds registered read data on mc_data while the MCU read is active; owns the sample FIFO.
`timescale 1ns/1ps
module mc_read_responder
  import mc_bus_pkg::*;
#(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6,
  parameter int FIFO_DEPTH    = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mc_ce,
  input  logic                     mc_oe,
  input  logic [MC_ADD_WIDTH-1:0]  mc_add,
  output logic [MC_DATA_WIDTH-1:0] mc_dout,
  output logic                     mc_doe,
  input  logic [MC_DATA_WIDTH-1:0] cfg_pwm,
  input  logic [4:0]               pin_state,
  input  logic                     sample_valid,
  input  logic [MC_DATA_WIDTH-1:0] sample_data,
  output logic [5:0]               fifo_level
);

  localparam logic [MC_ADD_WIDTH-1:0] A_ID     = MC_ADD_WIDTH'(MC_ADDR_ID);
  localparam logic [MC_ADD_WIDTH-1:0] A_STATUS = MC_ADD_WIDTH'(MC_ADDR_STATUS);
  localparam logic [MC_ADD_WIDTH-1:0] A_FIFO   = MC_ADD_WIDTH'(MC_ADDR_FIFO);
  localparam logic [MC_ADD_WIDTH-1:0] A_PINS   = MC_ADD_WIDTH'(MC_ADDR_PINS);
  localparam logic [MC_ADD_WIDTH-1:0] A_PWM    = MC_ADD_WIDTH'(MC_ADDR_PWM);

  logic [SYNC_STAGES-1:0]  ce_sync_q, ce_sync_d;
  logic [SYNC_STAGES-1:0]  oe_sync_q, oe_sync_d;
  logic [MC_ADD_WIDTH-1:0] add_sync_q [SYNC_STAGES];
  logic [MC_ADD_WIDTH-1:0] add_sync_d [SYNC_STAGES];

  always_comb begin
    ce_sync_d[0]  = mc_ce;
    oe_sync_d[0]  = mc_oe;
    add_sync_d[0] = mc_add;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      ce_sync_d[i]  = ce_sync_q[i-1];
      oe_sync_d[i]  = oe_sync_q[i-1];
      add_sync_d[i] = add_sync_q[i-1];
    end
  end

  // NOTE: synchronisers are deliberately not reset so they track the pins during reset;
  // that lets ARM see a read already in flight when reset releases.
  always_ff @(posedge clock) begin
    ce_sync_q  <= ce_sync_d;
    oe_sync_q  <= oe_sync_d;
    add_sync_q <= add_sync_d;
  end

  logic                    rd_act;
  logic [MC_ADD_WIDTH-1:0] addr_s;
  assign rd_act = !ce_sync_q[SYNC_STAGES-1] && !oe_sync_q[SYNC_STAGES-1];
  assign addr_s = add_sync_q[SYNC_STAGES-1];

  logic [MC_DATA_WIDTH-1:0] fifo_rdata;
  logic                     fifo_full, fifo_empty, fifo_pop;
  logic [5:0]               fifo_lvl;

  sync_fifo #(
    .WIDTH   (MC_DATA_WIDTH),
    .DEPTH   (FIFO_DEPTH),
    .LEVEL_W (6)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (sample_valid),
    .pop   (fifo_pop),
    .wdata (sample_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_lvl)
  );

  assign fifo_level = fifo_lvl;

  rd_state_e                state_q, state_d;
  logic [MC_ADD_WIDTH-1:0]  addr_q, addr_d;
  logic [MC_DATA_WIDTH-1:0] mc_dout_q, mc_dout_d;
  logic                     mc_doe_q, mc_doe_d;
  logic                     ovf_q, ovf_d;
  logic                     udf_q, udf_d;
  logic [MC_DATA_WIDTH-1:0] rd_mux;
  logic                     drive_exit;

  // Empty FIFO reads return zero rather than whatever stale word sits at the head.
  always_comb begin
    rd_mux = '0;
    unique case (addr_s)
      A_ID: rd_mux = MC_DATA_WIDTH'(MC_ID_VALUE);
      A_STATUS: begin
        rd_mux[STAT_OVERFLOW]      = ovf_q;
        rd_mux[STAT_UNDERFLOW]     = udf_q;
        rd_mux[STAT_EMPTY]         = fifo_empty;
        rd_mux[STAT_FULL]          = fifo_full;
        rd_mux[STAT_LEVEL_W-1:0]   = fifo_lvl;
      end
      A_FIFO:  rd_mux = fifo_empty ? '0 : fifo_rdata;
      A_PINS:  rd_mux = MC_DATA_WIDTH'(pin_state);
      A_PWM:   rd_mux = cfg_pwm;
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mc_dout_d  = mc_dout_q;
    mc_doe_d   = mc_doe_q;
    drive_exit = 1'b0;
    unique case (state_q)
      RD_ARM: begin
        mc_doe_d = 1'b0;
        if (!rd_act) state_d = RD_IDLE;
      end
      RD_IDLE: begin
        if (rd_act) begin
          addr_d    = addr_s;
          mc_dout_d = rd_mux;
          mc_doe_d  = 1'b1;
          state_d   = RD_DRIVE;
        end
      end
      RD_DRIVE: begin
        if (!rd_act) begin
          mc_doe_d   = 1'b0;
          drive_exit = 1'b1;
          state_d    = RD_IDLE;
        end
      end
      default: begin
        mc_doe_d = 1'b0;
        state_d  = RD_ARM;
      end
    endcase
  end

  // Side effects fire on the DRIVE exit edge so the driven word never changes under the MCU.
  logic stat_clr, udf_set, ovf_set;
  assign fifo_pop = drive_exit && (addr_q == A_FIFO) && !fifo_empty;
  assign udf_set  = drive_exit && (addr_q == A_FIFO) && fifo_empty;
  assign stat_clr = drive_exit && (addr_q == A_STATUS);
  assign ovf_set  = sample_valid && fifo_full && !fifo_pop;

  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (stat_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (ovf_set) ovf_d = 1'b1;
    if (udf_set) udf_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RD_ARM;
      addr_q    <= '0;
      mc_dout_q <= '0;
      mc_doe_q  <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      mc_dout_q <= mc_dout_d;
      mc_doe_q  <= mc_doe_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  assign mc_dout = mc_dout_q;
  assign mc_doe  = mc_doe_q;

endmodule

// File: tb/tb_mc_read_responder.sv
// Directed bench for mc_read_responder: register-read vector table plus hand-written
// FIFO, overflow, push/pop-while-full, drive-freeze and reset-during-read sequences.
`timescale 1ns/1ps
module tb_mc_read_responder;

  localparam int SS = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        mc_ce, mc_oe;
  logic [5:0]  mc_add;
  logic [15:0] mc_dout;
  logic        mc_doe;
  logic [15:0] cfg_pwm;
  logic [4:0]  pin_state;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic [5:0]  fifo_level;

  mc_read_responder #(
    .MC_DATA_WIDTH (16),
    .MC_ADD_WIDTH  (6),
    .FIFO_DEPTH    (16),
    .SYNC_STAGES   (SS)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .mc_ce        (mc_ce),
    .mc_oe        (mc_oe),
    .mc_add       (mc_add),
    .mc_dout      (mc_dout),
    .mc_doe       (mc_doe),
    .cfg_pwm      (cfg_pwm),
    .pin_state    (pin_state),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .fifo_level   (fifo_level)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Assert the strobes and wait (bounded) for mc_doe; latency counted in clock edges.
  task automatic bus_start(input logic [5:0] a, output int lat);
    mc_add = a;
    mc_ce  = 1'b0;
    mc_oe  = 1'b0;
    lat    = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (mc_doe === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic bus_end(output int lat);
    mc_oe = 1'b1;
    mc_ce = 1'b1;
    lat   = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (mc_doe === 1'b0) begin
        lat = i;
        break;
      end
    end
    tick(2);
  endtask

  task automatic read_chk(input string name, input logic [5:0] a, input logic [15:0] exp);
    int          lat_on, lat_off;
    logic [15:0] data;
    bus_start(a, lat_on);
    data = mc_dout;
    check({name, "_doe_rise"}, lat_on, SS + 1);
    check({name, "_data"}, data, exp);
    bus_end(lat_off);
    check({name, "_doe_fall"}, (lat_off >= 1 && lat_off <= SS + 1), 1);
  endtask

  task automatic push_word(input logic [15:0] w);
    sample_data  = w;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  typedef struct {
    logic [5:0]  addr;
    logic [4:0]  pins;
    logic [15:0] pwm;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          highs;
    logic [15:0] w;

    vecs.push_back('{6'h00, 5'h00, 16'h0000, 16'hB9A1});
    vecs.push_back('{6'h01, 5'h00, 16'h0000, 16'h2000});
    vecs.push_back('{6'h03, 5'h15, 16'h0000, 16'h0015});
    vecs.push_back('{6'h03, 5'h0A, 16'h0000, 16'h000A});
    vecs.push_back('{6'h03, 5'h1F, 16'h0000, 16'h001F});
    vecs.push_back('{6'h19, 5'h00, 16'h1234, 16'h1234});
    vecs.push_back('{6'h19, 5'h00, 16'hFFFF, 16'hFFFF});
    vecs.push_back('{6'h04, 5'h1F, 16'hFFFF, 16'h0000});
    vecs.push_back('{6'h18, 5'h1F, 16'hABCD, 16'h0000});
    vecs.push_back('{6'h1A, 5'h1F, 16'hABCD, 16'h0000});
    vecs.push_back('{6'h3F, 5'h1F, 16'hABCD, 16'h0000});
    vecs.push_back('{6'h01, 5'h00, 16'h0000, 16'h2000});

    reset        = 1'b1;
    mc_ce        = 1'b1;
    mc_oe        = 1'b1;
    mc_add       = 6'h00;
    cfg_pwm      = 16'h0000;
    pin_state    = 5'h00;
    sample_valid = 1'b0;
    sample_data  = 16'h0000;
    tick(3);
    check("rst_doe", mc_doe, 0);
    check("rst_dout", mc_dout, 0);
    check("rst_level", fifo_level, 0);
    reset = 1'b0;
    tick(2);

    // Register-read table.
    foreach (vecs[i]) begin
      pin_state = vecs[i].pins;
      cfg_pwm   = vecs[i].pwm;
      read_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end

    // FIFO basic order, underflow and its clear-on-read.
    push_word(16'h1111);
    push_word(16'h2222);
    push_word(16'h3333);
    check("fifo_level3", fifo_level, 3);
    read_chk("pop1", 6'h02, 16'h1111);
    read_chk("pop2", 6'h02, 16'h2222);
    read_chk("pop3", 6'h02, 16'h3333);
    check("fifo_level0", fifo_level, 0);
    read_chk("pop_empty", 6'h02, 16'h0000);
    read_chk("stat_udf", 6'h01, 16'h6000);
    read_chk("stat_udf_clr", 6'h01, 16'h2000);

    // Overflow: 17 pushes into 16 entries.
    for (int i = 0; i < 17; i++) push_word(16'hA000 + 16'(i));
    check("ovf_level", fifo_level, 16);
    read_chk("stat_ovf", 6'h01, 16'h9010);

    // Push on the DRIVE exit edge of a FIFO read while full.
    bus_start(6'h02, lat);
    check("sim_doe_rise", lat, SS + 1);
    check("sim_data", mc_dout, 16'hA000);
    mc_oe = 1'b1;
    mc_ce = 1'b1;
    tick(SS);
    check("sim_doe_pre_exit", mc_doe, 1);
    sample_data  = 16'hBEEF;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("sim_doe_exit", mc_doe, 0);
    check("sim_level", fifo_level, 16);
    tick(2);
    read_chk("sim_stat", 6'h01, 16'h1010);
    for (int i = 1; i < 16; i++) read_chk($sformatf("drain%0d", i), 6'h02, 16'hA000 + 16'(i));
    read_chk("drain_beef", 6'h02, 16'hBEEF);
    check("drain_level", fifo_level, 0);
    read_chk("drain_stat", 6'h01, 16'h2000);

    // Drive data stays frozen while address and source change mid-read.
    cfg_pwm = 16'h5A5A;
    bus_start(6'h19, lat);
    check("frz_data0", mc_dout, 16'h5A5A);
    mc_add  = 6'h00;
    cfg_pwm = 16'h0000;
    tick(4);
    check("frz_doe", mc_doe, 1);
    check("frz_data1", mc_dout, 16'h5A5A);
    bus_end(lat);
    check("frz_doe_fall", (lat >= 1 && lat <= SS + 1), 1);

    // Reset during DRIVE, strobes held low across reset release.
    bus_start(6'h00, lat);
    check("rmid_doe_rise", lat, SS + 1);
    reset = 1'b1;
    tick();
    check("rmid_doe", mc_doe, 0);
    check("rmid_dout", mc_dout, 0);
    tick(2);
    reset = 1'b0;
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mc_doe !== 1'b0) highs++;
    end
    check("rmid_arm_hold", highs, 0);
    mc_oe = 1'b1;
    mc_ce = 1'b1;
    tick(SS + 2);
    read_chk("rmid_reread", 6'h00, 16'hB9A1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
